// File: rtl/lfsr_pkg.sv
// Shared definitions for the x^4 + x^3 + 1 LFSR generator/checker pair:
// register width, tap positions, FSM encoding and counter widths.
package lfsr_pkg;

  localparam int LFSR_W = 4;
  localparam int TAP_A  = 0;
  localparam int TAP_B  = 3;
  localparam int CNT_W  = 4;
  localparam int FILL_W = $clog2(LFSR_W + 1);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/lfsr_next.sv
// Next-bit prediction for the LFSR sequence: p = h[TAP_A] ^ h[TAP_B].
// Shared with the generator so the polynomial is defined once.
module lfsr_next
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] h,
  output logic              p
);

  assign p = h[TAP_A] ^ h[TAP_B];

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the period-15 LFSR bit stream: searches for
// lock, then flywheels its own prediction, flagging and counting mismatches.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [CNT_W-1:0]  LOCK_V = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0]  LOSS_V = CNT_W'(LOSS_CNT);
  localparam logic [FILL_W-1:0] FULL_V = FILL_W'(LFSR_W);

  state_t              state, state_n;
  logic [LFSR_W-1:0]   h, h_n;
  logic [FILL_W-1:0]   fill, fill_n;
  logic [CNT_W-1:0]    match_cnt, match_n;
  logic [CNT_W-1:0]    miss_cnt, miss_n;
  logic                err_pulse_n;
  logic [ERR_W-1:0]    err_count_n;
  logic                p;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  lfsr_next u_next (
    .h (h),
    .p (p)
  );

  always_comb begin
    state_n     = state;
    h_n         = h;
    fill_n      = fill;
    match_n     = match_cnt;
    miss_n      = miss_cnt;
    err_pulse_n = 1'b0;
    err_count_n = err_count;
    if (in_valid) begin
      if (state == SEARCH) begin
        h_n = {h[LFSR_W-2:0], in_bit};
        if (fill < FULL_V) begin
          fill_n = fill + FILL_W'(1);
        end else if (h == '0) begin
          // an all-zero history predicts zeros forever; never let it lock
          match_n = '0;
        end else if (in_bit == p) begin
          if (match_cnt + CNT_W'(1) == LOCK_V) begin
            state_n = LOCKED;
            match_n = '0;
            miss_n  = '0;
          end else begin
            match_n = match_cnt + CNT_W'(1);
          end
        end else begin
          match_n = '0;
        end
      end else begin
        // flywheel: history follows our own prediction, not the line
        h_n = {h[LFSR_W-2:0], p};
        if (in_bit == p) begin
          miss_n = '0;
        end else begin
          err_pulse_n = 1'b1;
          err_count_n = sat_inc(err_count);
          if (miss_cnt + CNT_W'(1) == LOSS_V) begin
            state_n = SEARCH;
            fill_n  = '0;
            h_n     = '0;
            match_n = '0;
            miss_n  = '0;
          end else begin
            miss_n = miss_cnt + CNT_W'(1);
          end
        end
      end
    end
    if (clr_err) err_count_n = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      h         <= '0;
      fill      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      h         <= h_n;
      fill      <= fill_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      err_pulse <= err_pulse_n;
      err_count <= err_count_n;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised and directed bench for lfsr_checker against a sequence-level
// reference model that tracks stream phase in the period-15 table.
module tb_lfsr_checker;

  localparam int LOCK_CNT = 8;
  localparam int LOSS_CNT = 3;
  localparam int ERR_W    = 8;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_bit = 1'b0;
  logic             in_valid = 1'b0;
  logic             clr_err = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;

  int n_chk  = 0;
  int n_fail = 0;

  int tbl[15] = '{1,0,0,0,1,1,1,1,0,1,0,1,1,0,0};
  int gidx = 0;

  // reference model state
  int m_locked = 0;
  int m_pulse  = 0;
  int m_count  = 0;
  int m_match  = 0;
  int m_miss   = 0;
  int m_phase  = 0;
  int q[$];

  lfsr_checker #(
    .LOCK_CNT (LOCK_CNT),
    .LOSS_CNT (LOSS_CNT),
    .ERR_W    (ERR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .clr_err   (clr_err),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input int b, input int v, input int c, input int r);
    int pred;
    bit zero;
    if (r != 0) begin
      m_locked = 0; m_pulse = 0; m_count = 0; m_match = 0; m_miss = 0;
      q.delete();
      return;
    end
    m_pulse = 0;
    if (v != 0) begin
      if (m_locked == 0) begin
        if (q.size() >= 4) begin
          zero = (q[0] == 0) && (q[1] == 0) && (q[2] == 0) && (q[3] == 0);
          pred = q[3] ^ q[0];
          if (zero) m_match = 0;
          else if (b == pred) m_match++;
          else m_match = 0;
        end
        q.push_back(b);
        if (q.size() > 4) void'(q.pop_front());
        if (m_match == LOCK_CNT) begin
          m_locked = 1; m_match = 0; m_miss = 0;
          // locate the last four bits in the sequence table
          for (int k = 0; k < 15; k++)
            if (tbl[k] == q[0] && tbl[(k+1)%15] == q[1] &&
                tbl[(k+2)%15] == q[2] && tbl[(k+3)%15] == q[3])
              m_phase = (k + 4) % 15;
        end
      end else begin
        pred = tbl[m_phase];
        m_phase = (m_phase + 1) % 15;
        if (b == pred) m_miss = 0;
        else begin
          m_pulse = 1;
          if (m_count < ERR_MAX) m_count++;
          m_miss++;
          if (m_miss == LOSS_CNT) begin
            m_locked = 0; m_miss = 0; m_match = 0;
            q.delete();
          end
        end
      end
    end
    if (c != 0) m_count = 0;
  endtask

  // one clock: drive, clock, update model, compare all outputs
  task automatic send(input int inv, input int v, input int c, input int r);
    int b;
    b = v ? (tbl[gidx] ^ inv) : 0;
    if (v) gidx = (gidx + 1) % 15;
    in_bit = b[0]; in_valid = v[0]; clr_err = c[0]; rst = r[0];
    @(posedge clk);
    model_edge(b, v, c, r);
    #1;
    chk("locked", int'(locked), m_locked);
    chk("err_pulse", int'(err_pulse), m_pulse);
    chk("err_count", int'(err_count), m_count);
  endtask

  initial begin
    send(0, 0, 0, 1);
    send(0, 0, 0, 1);
    chk("rst_locked", int'(locked), 0);
    chk("rst_count", int'(err_count), 0);
    chk("rst_pulse", int'(err_pulse), 0);

    // clean stream: lock exactly on the 12th bit
    gidx = 0;
    for (int i = 1; i <= 100; i++) begin
      send(0, 1, 0, 0);
      if (i == 11) chk("lock_not_yet", int'(locked), 0);
      if (i == 12) chk("lock_at_12", int'(locked), 1);
    end
    chk("clean_count", int'(err_count), 0);

    // single error
    send(1, 1, 0, 0);
    chk("single_pulse", int'(err_pulse), 1);
    chk("single_count", int'(err_count), 1);
    chk("single_locked", int'(locked), 1);
    send(0, 1, 0, 0);
    chk("single_pulse_drop", int'(err_pulse), 0);
    for (int i = 0; i < 29; i++) send(0, 1, 0, 0);
    chk("single_after", int'(err_count), 1);

    // burst of 3
    send(1, 1, 0, 0);
    send(1, 1, 0, 0);
    chk("burst_locked2", int'(locked), 1);
    send(1, 1, 0, 0);
    chk("burst_drop", int'(locked), 0);
    chk("burst_pulse3", int'(err_pulse), 1);
    chk("burst_count", int'(err_count), 4);
    for (int i = 1; i <= 12; i++) begin
      send(0, 1, 0, 0);
      if (i == 11) chk("relock_not_yet", int'(locked), 0);
    end
    chk("relock_12", int'(locked), 1);

    // all-zero stream
    send(0, 0, 0, 1);
    for (int i = 0; i < 100; i++) begin
      in_bit = 1'b0; in_valid = 1'b1; clr_err = 1'b0; rst = 1'b0;
      @(posedge clk);
      model_edge(0, 1, 0, 0);
      #1;
      chk("zero_locked", int'(locked), 0);
      chk("zero_count", int'(err_count), m_count);
    end

    // sparse valid: every third cycle
    send(0, 0, 0, 1);
    gidx = 5;
    for (int i = 1; i <= 12; i++) begin
      send(0, 0, 0, 0);
      send(0, 0, 0, 0);
      if (i == 12) chk("sparse_idle", int'(locked), 0);
      send(0, 1, 0, 0);
    end
    chk("sparse_lock", int'(locked), 1);

    // clear colliding with an error
    send(1, 1, 0, 0);
    chk("pre_clr_count", int'(err_count), 1);
    send(1, 1, 1, 0);
    chk("clr_count", int'(err_count), 0);
    chk("clr_pulse", int'(err_pulse), 1);
    send(0, 1, 0, 0);

    // reset while locked, then relock in 12
    chk("pre_rst_locked", int'(locked), 1);
    send(0, 1, 0, 1);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_count", int'(err_count), 0);
    for (int i = 1; i <= 12; i++) send(0, 1, 0, 0);
    chk("rst_relock", int'(locked), 1);

    // saturation: alternate errors so lock is held
    for (int i = 0; i < 300; i++) begin
      send(1, 1, 0, 0);
      send(0, 1, 0, 0);
    end
    chk("sat_count", int'(err_count), ERR_MAX);
    chk("sat_locked", int'(locked), 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      send(($urandom_range(0, 99) < 6) ? 1 : 0,
           ($urandom_range(0, 99) < 75) ? 1 : 0,
           ($urandom_range(0, 99) < 2) ? 1 : 0,
           ($urandom_range(0, 999) < 3) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
